// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Requesters are arbitrated round-robin. The winner's operands are captured, the ALU is given
// one cycle, and the result is registered. It is then returned on the winner's private response
// channel. Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   reqX_valid/ready              request handshake for requester X (0/1)
//   reqX_a, reqX_b, reqX_sel      operands and ALU op code
//   respX_valid/ready             response handshake for requester X
//   respX_res, respX_err          result and unsupported-op flag (zero when not valid)
//   alu_a, alu_b, alu_sel         drive to the shared ALU (straight from registers)
//   alu_res                       result from the shared ALU
module alu_arbiter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [3:0]   req0_sel,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [3:0]   req1_sel,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic [N-1:0] resp0_res,
  output logic         resp0_err,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [N-1:0] resp1_res,
  output logic         resp1_err,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_res
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] op_a_q, op_b_q, res_q;
  logic [3:0]   op_sel_q;
  logic         owner_q, prio_q, err_q;
  logic         gnt0, gnt1, accept, sel_ok;

  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1111: sel_legal = 1'b1;
      default:                                     sel_legal = 1'b0;
    endcase
  endfunction

  // Round-robin: an unopposed requester always wins; under contention prio_q decides.
  assign gnt0   = req0_valid & (~req1_valid | ~prio_q);
  assign gnt1   = req1_valid & (~req0_valid | prio_q);
  assign accept = (state_q == StIdle) & (gnt0 | gnt1);
  assign sel_ok = sel_legal(op_sel_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StExec;
      StExec: state_d = StResp;
      StResp: if (owner_q ? resp1_ready : resp0_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    req0_ready  = (state_q == StIdle) & gnt0;
    req1_ready  = (state_q == StIdle) & gnt1;
    resp0_valid = (state_q == StResp) & ~owner_q;
    resp1_valid = (state_q == StResp) & owner_q;
    resp0_res   = resp0_valid ? res_q : '0;
    resp1_res   = resp1_valid ? res_q : '0;
    resp0_err   = resp0_valid & err_q;
    resp1_err   = resp1_valid & err_q;
    alu_a       = op_a_q;
    alu_b       = op_b_q;
    alu_sel     = op_sel_q;
  end

  // Operand capture, ownership, priority pointer and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_sel_q <= '0;
      owner_q  <= 1'b0;
      prio_q   <= 1'b0;
      res_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        if (gnt0) begin
          op_a_q   <= req0_a;
          op_b_q   <= req0_b;
          op_sel_q <= req0_sel;
        end else begin
          op_a_q   <= req1_a;
          op_b_q   <= req1_b;
          op_sel_q <= req1_sel;
        end
        owner_q <= gnt1;
        prio_q  <= gnt0; // hand priority to the other requester
      end
      if (state_q == StExec) begin
        // Unsupported codes return a clean zero regardless of what the ALU produces.
        res_q <= sel_ok ? alu_res : '0;
        err_q <= ~sel_ok;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]   req0_sel, req1_sel;
  logic         resp0_valid, resp0_ready, resp0_err, resp1_valid, resp1_ready, resp1_err;
  logic [N-1:0] resp0_res, resp1_res;
  logic [N-1:0] alu_a, alu_b, alu_res;
  logic [3:0]   alu_sel;

  typedef struct packed {
    logic         port;
    logic [N-1:0] res;
    logic         err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .resp0_valid(resp0_valid),
    .resp0_ready(resp0_ready),
    .resp0_res  (resp0_res),
    .resp0_err  (resp0_err),
    .resp1_valid(resp1_valid),
    .resp1_ready(resp1_ready),
    .resp1_res  (resp1_res),
    .resp1_err  (resp1_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_res    (alu_res)
  );

  // Reference ALU; unsupported codes deliberately return non-zero garbage.
  always_comb begin
    alu_res = alu_a + alu_b + 32'd1;
    case (alu_sel)
      4'b0000: alu_res = alu_a + alu_b;
      4'b0001: alu_res = alu_a << alu_b[4:0];
      4'b0010: alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0101: alu_res = alu_a >> alu_b[4:0];
      4'b0110: alu_res = alu_a | alu_b;
      4'b0111: alu_res = alu_a & alu_b;
      4'b1100: alu_res = alu_a - alu_b;
      4'b1101: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      4'b1111: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic [N-1:0] res, input logic err);
    exp_t e;
    e.port = port;
    e.res  = res;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  // Monitor: invariants, idle bus values, hold stability during stalls, scoreboard pops.
  initial begin
    logic         stall0, stall1, herr0, herr1;
    logic [N-1:0] hres0, hres1;
    exp_t         e;
    stall0 = 1'b0;
    stall1 = 1'b0;
    herr0  = 1'b0;
    herr1  = 1'b0;
    hres0  = '0;
    hres1  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall0 = 1'b0;
        stall1 = 1'b0;
      end else begin
        check("ready_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
        check("valid_onehot", {63'd0, resp0_valid & resp1_valid}, 64'd0);
        if (!resp0_valid) check("resp0_idle_bus", {31'd0, resp0_err, resp0_res}, 64'd0);
        if (!resp1_valid) check("resp1_idle_bus", {31'd0, resp1_err, resp1_res}, 64'd0);
        if (stall0) check("resp0_hold", {30'd0, resp0_valid, resp0_err, resp0_res},
                          {30'd0, 1'b1, herr0, hres0});
        if (stall1) check("resp1_hold", {30'd0, resp1_valid, resp1_err, resp1_res},
                          {30'd0, 1'b1, herr1, hres1});
        stall0 = resp0_valid & ~resp0_ready;
        stall1 = resp1_valid & ~resp1_ready;
        hres0  = resp0_res;
        herr0  = resp0_err;
        hres1  = resp1_res;
        herr1  = resp1_err;
        if (resp0_valid && resp0_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL resp0_unexpected: got res 0x%0h, expected no response", resp0_res);
          end else begin
            e = sb_q.pop_front();
            check("resp0_port", 64'd0, {63'd0, e.port});
            check("resp0_res", {32'd0, resp0_res}, {32'd0, e.res});
            check("resp0_err", {63'd0, resp0_err}, {63'd0, e.err});
          end
        end
        if (resp1_valid && resp1_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL resp1_unexpected: got res 0x%0h, expected no response", resp1_res);
          end else begin
            e = sb_q.pop_front();
            check("resp1_port", 64'd1, {63'd0, e.port});
            check("resp1_res", {32'd0, resp1_res}, {32'd0, e.res});
            check("resp1_err", {63'd0, resp1_err}, {63'd0, e.err});
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic port, input logic v, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [3:0] sel);
    if (port) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_sel = sel;
    end
  endtask

  task automatic wait_ready(input logic port, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got no ready on port %0d, expected ready", port);
    end
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run_req(input logic port, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [3:0] sel, input logic [N-1:0] eres, input logic eerr);
    logic ok;
    set_req(port, 1'b1, a, b, sel);
    wait_ready(port, ok);
    if (ok) push(port, eres, eerr);
    step();
    set_req(port, 1'b0, '0, '0, 4'd0);
    wait_drain();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string name);
    check(name, {58'd0, req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_err, resp1_err},
          64'd0);
    check({name, "_res"}, {resp0_res, resp1_res}, 64'd0);
    check({name, "_alu"}, {alu_a, alu_b}, 64'd0);
    check({name, "_sel"}, {60'd0, alu_sel}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   cnt;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;

    // Reset state
    #12;
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Single add: 5 + 7
    set_req(1'b0, 1'b1, 32'd5, 32'd7, 4'b0000);
    @(negedge clk);
    check("add_req0_ready", {63'd0, req0_ready}, 64'd1);
    check("add_req1_ready", {63'd0, req1_ready}, 64'd0);
    push(1'b0, 32'd12, 1'b0);
    step();
    set_req(1'b0, 1'b0, '0, '0, 4'd0);
    @(negedge clk);
    check("add_alu_ops", {alu_a, alu_b}, {32'd5, 32'd7});
    check("add_alu_sel", {60'd0, alu_sel}, 64'd0);
    check("add_exec_valid", {63'd0, resp0_valid}, 64'd0);
    step();
    @(negedge clk);
    check("add_resp0_valid", {63'd0, resp0_valid}, 64'd1);
    check("add_resp0_res", {32'd0, resp0_res}, 64'd12);
    check("add_resp1_valid", {63'd0, resp1_valid}, 64'd0);
    step();
    wait_drain();
    step();

    // Contention: grants alternate 0,1,0,1 at a 3-cycle interval
    do_reset();
    set_req(1'b0, 1'b1, 32'd9, 32'd4, 4'b1100);
    set_req(1'b1, 1'b1, 32'h8000_0000, 32'd4, 4'b1101);
    for (int g = 0; g < 4; g++) begin
      cnt = 0;
      ok  = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        cnt++;
        if (req0_ready || req1_ready) begin
          ok = 1'b1;
          break;
        end
      end
      check("rr_grant", {62'd0, req1_ready, ok}, {62'd0, g[0], 1'b1});
      if (g > 0) check("rr_interval", 64'(cnt), 64'd3);
      if (ok) push(g[0], g[0] ? 32'hF800_0000 : 32'd5, 1'b0);
      step();
    end
    set_req(1'b0, 1'b0, '0, '0, 4'd0);
    set_req(1'b1, 1'b0, '0, '0, 4'd0);
    wait_drain();
    step();

    // Backpressure on resp1; req0 waits throughout
    resp1_ready = 1'b0;
    set_req(1'b1, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0100);
    wait_ready(1'b1, ok);
    if (ok) push(1'b1, 32'h0000_FF00, 1'b0);
    step();
    set_req(1'b1, 1'b0, '0, '0, 4'd0);
    set_req(1'b0, 1'b1, 32'd1, 32'd1, 4'b0000);
    @(negedge clk);
    check("bp_exec_req0_ready", {63'd0, req0_ready}, 64'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stall", {31'd0, resp1_valid, resp1_res}, {31'd0, 1'b1, 32'h0000_FF00});
      check("bp_req0_blocked", {63'd0, req0_ready}, 64'd0);
      step();
    end
    resp1_ready = 1'b1;
    @(negedge clk);
    check("bp_handshake", {62'd0, resp1_valid, req0_ready}, {62'd0, 1'b1, 1'b0});
    step();
    @(negedge clk);
    check("bp_next_accept", {63'd0, req0_ready}, 64'd1);
    push(1'b0, 32'd2, 1'b0);
    step();
    set_req(1'b0, 1'b0, '0, '0, 4'd0);
    wait_drain();
    step();

    // Illegal op then legal slt
    run_req(1'b0, 32'd3, 32'd3, 4'b1000, 32'd0, 1'b1);
    run_req(1'b0, 32'd1, 32'd2, 4'b0010, 32'd1, 1'b0);
    run_req(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd1, 1'b0);
    run_req(1'b1, 32'd5, 32'd5, 4'b1110, 32'd0, 1'b1);

    // Reset during EXEC of req1
    set_req(1'b1, 1'b1, 32'd2, 32'd3, 4'b0000);
    wait_ready(1'b1, ok);
    step();
    set_req(1'b1, 1'b0, '0, '0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midop_reset");
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      check("midop_no_resp", {62'd0, resp0_valid, resp1_valid}, 64'd0);
    end
    step();
    set_req(1'b0, 1'b1, 32'd10, 32'd20, 4'b0000);
    set_req(1'b1, 1'b1, 32'd2, 32'd3, 4'b0000);
    @(negedge clk);
    check("midop_prio", {62'd0, req0_ready, req1_ready}, {62'd0, 1'b1, 1'b0});
    push(1'b0, 32'd30, 1'b0);
    step();
    set_req(1'b0, 1'b0, '0, '0, 4'd0);
    set_req(1'b1, 1'b0, '0, '0, 4'd0);
    wait_drain();
    step();

    // Withdrawal: req0 pulses while req1 sits in RESP
    resp1_ready = 1'b0;
    set_req(1'b1, 1'b1, 32'h0000_00FF, 32'h0000_000F, 4'b0111);
    wait_ready(1'b1, ok);
    if (ok) push(1'b1, 32'h0000_000F, 1'b0);
    step();
    set_req(1'b1, 1'b0, '0, '0, 4'd0);
    step();
    set_req(1'b0, 1'b1, 32'd4, 32'd4, 4'b0000);
    @(negedge clk);
    check("wd_req0_ready", {63'd0, req0_ready}, 64'd0);
    step();
    set_req(1'b0, 1'b0, '0, '0, 4'd0);
    step();
    resp1_ready = 1'b1;
    wait_drain();
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check("wd_no_resp0", {63'd0, resp0_valid}, 64'd0);
    end
    check("wd_ops_kept", {alu_a, alu_b}, {32'h0000_00FF, 32'h0000_000F});

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
